// File: rtl/attrib_pkg.sv
// Shared constants for the attribute/palette stage: register map, flip-flop states, MODE bits.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package attrib_pkg;

    localparam logic [4:0] REG_MODE       = 5'h10;
    localparam logic [4:0] REG_OVERSCAN   = 5'h11;
    localparam logic [4:0] REG_PLANE_EN   = 5'h12;

    // MODE register bit that selects attribute bit 7 as blink instead of bright background
    localparam int         MODE_BLINK_BIT = 3;

    typedef enum logic {
        FF_INDEX = 1'b0,
        FF_DATA  = 1'b1
    } ff_state_t;

endpackage

// File: rtl/attrib_blink_gen.sv
// Counts vsync rising edges and produces the cursor and character blink phases.
// Latency: phases update on the pix_ce cycle that samples the vsync rising edge.
// Backpressure: all state holds while pix_ce is low.
module attrib_blink_gen #(
    parameter int CURSOR_FRAMES = 8,
    parameter int CNT_W         = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic pix_ce,
    input  logic vsync,
    output logic cursor_ph,
    output logic char_ph
);

    logic             vsync_q;
    logic [CNT_W-1:0] frame_cnt;
    logic             vsync_rise;

    assign vsync_rise = pix_ce & vsync & ~vsync_q;

    // Frame counter; character blink runs at half the cursor rate by toggling on cursor 0->1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            frame_cnt <= '0;
            cursor_ph <= 1'b0;
            char_ph   <= 1'b0;
        end else if (pix_ce) begin
            vsync_q <= vsync;
            if (vsync_rise) begin
                if (frame_cnt == CNT_W'(CURSOR_FRAMES - 1)) begin
                    frame_cnt <= '0;
                    cursor_ph <= ~cursor_ph;
                    if (!cursor_ph) begin
                        char_ph <= ~char_ph;
                    end
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/attrib_palette_ctl.sv
// Attribute stage: text/graphics pixel -> 4-bit index -> palette colour, with sync/DE kept aligned.
// Latency: 2 pix_ce cycles from pixel inputs to pix_out/hsync_out/vsync_out/de_out.
// Backpressure: pipeline holds while pix_ce is low; bus writes are accepted every cycle.
module attrib_palette_ctl
    import attrib_pkg::*;
#(
    parameter int COLOR_W       = 6,
    parameter int CURSOR_FRAMES = 8,
    parameter int CNT_W         = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pix_ce,
    input  logic               bus_wr,
    input  logic [7:0]         bus_din,
    input  logic               ff_clr,
    input  logic [7:0]         att_byte,
    input  logic               pix_in,
    input  logic [3:0]         pix_gfx,
    input  logic               grph_mode,
    input  logic               cursor,
    input  logic               display_enable,
    input  logic               hsync,
    input  logic               vsync,
    output logic [COLOR_W-1:0] pix_out,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               de_out
);

    ff_state_t          ff_q, ff_d;
    logic               wr_en;
    logic [4:0]         reg_idx;
    logic               pas;
    logic [COLOR_W-1:0] palette [16];
    logic               blink_en;
    logic [COLOR_W-1:0] overscan;
    logic [3:0]         plane_en;

    logic               cursor_ph, char_ph;
    logic [3:0]         bg, idx_next;
    logic               hidden, dot;

    logic [3:0]         idx_s1;
    logic               use_os_s1, hs_s1, vs_s1, de_s1;

    // Upper data bits only matter for wider palettes / the unused index-write bits
    logic               unused_din;
    assign unused_din = &{1'b0, bus_din[7:6]};

    // A status-register read (ff_clr) wins over and swallows a same-cycle write
    assign wr_en = bus_wr & ~ff_clr;

    attrib_blink_gen #(
        .CURSOR_FRAMES(CURSOR_FRAMES),
        .CNT_W        (CNT_W)
    ) u_blink (
        .clk      (clk),
        .reset    (reset),
        .pix_ce   (pix_ce),
        .vsync    (vsync),
        .cursor_ph(cursor_ph),
        .char_ph  (char_ph)
    );

    // Index/data flip-flop state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff_q <= FF_INDEX;
        else       ff_q <= ff_d;
    end

    // Flip-flop next state: clear to INDEX, otherwise alternate on each write
    always_comb begin
        ff_d = ff_q;
        if (ff_clr) begin
            ff_d = FF_INDEX;
        end else if (bus_wr) begin
            ff_d = (ff_q == FF_INDEX) ? FF_DATA : FF_INDEX;
        end
    end

    // Register file: index/PAS latch in INDEX phase, register write in DATA phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_idx  <= '0;
            pas      <= 1'b0;
            blink_en <= 1'b1;
            overscan <= '0;
            plane_en <= 4'hF;
            for (int i = 0; i < 16; i++) begin
                palette[i] <= COLOR_W'(i);
            end
        end else if (wr_en) begin
            if (ff_q == FF_INDEX) begin
                reg_idx <= bus_din[4:0];
                pas     <= bus_din[5];
            end else if (!reg_idx[4]) begin
                palette[reg_idx[3:0]] <= bus_din[COLOR_W-1:0];
            end else begin
                case (reg_idx)
                    REG_MODE:     blink_en <= bus_din[MODE_BLINK_BIT];
                    REG_OVERSCAN: overscan <= bus_din[COLOR_W-1:0];
                    REG_PLANE_EN: plane_en <= bus_din[3:0];
                    default:      ;
                endcase
            end
        end
    end

    // Colour index from graphics pixel or text dot/attribute/cursor/blink
    always_comb begin
        bg       = blink_en ? {1'b0, att_byte[6:4]} : att_byte[7:4];
        hidden   = blink_en & att_byte[7] & char_ph & ~cursor;
        dot      = (pix_in & ~hidden) | (cursor & cursor_ph);
        idx_next = dot ? att_byte[3:0] : bg;
        if (grph_mode) begin
            idx_next = pix_gfx & plane_en;
        end
    end

    // Stage 1: register index, overscan select and timing signals
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_s1    <= '0;
            use_os_s1 <= 1'b0;
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            de_s1     <= 1'b0;
        end else if (pix_ce) begin
            idx_s1    <= idx_next;
            use_os_s1 <= ~display_enable | ~pas;
            hs_s1     <= hsync;
            vs_s1     <= vsync;
            de_s1     <= display_enable;
        end
    end

    // Stage 2: blank during sync, overscan outside display or when palette access is off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_out   <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            de_out    <= 1'b0;
        end else if (pix_ce) begin
            if (hs_s1 | vs_s1)  pix_out <= '0;
            else if (use_os_s1) pix_out <= overscan;
            else                pix_out <= palette[idx_s1];
            hsync_out <= hs_s1;
            vsync_out <= vs_s1;
            de_out    <= de_s1;
        end
    end

endmodule

// File: tb/tb_attrib_palette_ctl.sv
// Randomized and directed stimulus against a behavioural model, scoreboard-checked.
// Latency: expected colour is queued when its pixel is sampled, popped two pix_ce edges later.
// Backpressure: on stalled edges the outputs must hold the last expected values.
module tb_attrib_palette_ctl;

    localparam int CF = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_ce, bus_wr, ff_clr, pix_in, grph_mode, cursor, display_enable, hsync, vsync;
    logic [7:0] bus_din, att_byte;
    logic [3:0] pix_gfx;
    logic [5:0] pix_out;
    logic       hsync_out, vsync_out, de_out;

    attrib_palette_ctl #(.COLOR_W(6), .CURSOR_FRAMES(CF), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .bus_wr(bus_wr), .bus_din(bus_din),
        .ff_clr(ff_clr), .att_byte(att_byte), .pix_in(pix_in), .pix_gfx(pix_gfx),
        .grph_mode(grph_mode), .cursor(cursor), .display_enable(display_enable),
        .hsync(hsync), .vsync(vsync), .pix_out(pix_out), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .de_out(de_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] pix;
        logic       hs, vs, de;
    } exp_t;

    typedef struct packed {
        logic       ce, wr, clr;
        logic [7:0] din, att;
        logic       pin;
        logic [3:0] gfx;
        logic       gm, cur, de, hs, vs;
    } stim_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q[$];

    // Reference model state
    logic [5:0] m_pal [16];
    logic       m_blink, m_ff, m_pas, m_vs_prev;
    logic [5:0] m_os;
    logic [3:0] m_plane;
    logic [4:0] m_idx;
    int         m_rises;
    // Pixel sampled into the pipeline but not yet coloured
    logic [3:0] p_idx;
    logic       p_use_os, p_hs, p_vs, p_de;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_pal[i] = 6'(i);
        m_blink = 1'b1; m_ff = 1'b0; m_pas = 1'b0; m_vs_prev = 1'b0;
        m_os = '0; m_plane = 4'hF; m_idx = '0; m_rises = 0;
        p_idx = '0; p_use_os = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_de = 1'b0;
        q.delete();
    endtask

    // Colour index from the written rules; blink phases follow from the count of vsync edges
    function automatic logic [3:0] model_index(input stim_t s);
        bit         cur_on  = ((m_rises / CF) % 2) == 1;
        bit         chr_off = (((m_rises + CF) / (2 * CF)) % 2) == 1;
        bit         blinking;
        bit         lit;
        logic [3:0] bg;
        if (s.gm) return s.gfx & m_plane;
        if (m_blink) begin
            bg       = {1'b0, s.att[6:4]};
            blinking = s.att[7] && chr_off && !s.cur;
        end else begin
            bg       = s.att[7:4];
            blinking = 1'b0;
        end
        lit = (s.pin && !blinking) || (s.cur && cur_on);
        return lit ? s.att[3:0] : bg;
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.ce = 1'b1;
        s.de = 1'b1;
        return s;
    endfunction

    // One clock: drive inputs, queue expectations for a pix_ce edge, then advance the model
    task automatic step(input stim_t s);
        exp_t e;
        @(negedge clk);
        pix_ce = s.ce; bus_wr = s.wr; ff_clr = s.clr; bus_din = s.din; att_byte = s.att;
        pix_in = s.pin; pix_gfx = s.gfx; grph_mode = s.gm; cursor = s.cur;
        display_enable = s.de; hsync = s.hs; vsync = s.vs;
        if (s.ce) begin
            e.pix = (p_hs || p_vs) ? 6'h00 : (p_use_os ? m_os : m_pal[p_idx]);
            e.hs  = p_hs; e.vs = p_vs; e.de = p_de;
            q.push_back(e);
            p_idx    = model_index(s);
            p_use_os = !s.de || !m_pas;
            p_hs     = s.hs; p_vs = s.vs; p_de = s.de;
        end
        @(posedge clk);
        if (s.clr) begin
            m_ff = 1'b0;
        end else if (s.wr) begin
            if (!m_ff) begin
                m_idx = s.din[4:0];
                m_pas = s.din[5];
            end else if (m_idx < 5'h10) begin
                m_pal[m_idx[3:0]] = s.din[5:0];
            end else if (m_idx == 5'h10) begin
                m_blink = s.din[3];
            end else if (m_idx == 5'h11) begin
                m_os = s.din[5:0];
            end else if (m_idx == 5'h12) begin
                m_plane = s.din[3:0];
            end
            m_ff = !m_ff;
        end
        if (s.ce) begin
            if (s.vs && !m_vs_prev) m_rises++;
            m_vs_prev = s.vs;
        end
    endtask

    task automatic bus_write(input logic [7:0] d);
        stim_t s = idle();
        s.ce = 1'b0; s.wr = 1'b1; s.din = d;
        step(s);
    endtask

    task automatic bus_clear();
        stim_t s = idle();
        s.ce = 1'b0; s.clr = 1'b1;
        step(s);
    endtask

    task automatic check_now(input string name, input logic [5:0] pix, input logic hs);
        #2;
        chk({name, "_pix"}, 32'(pix_out), 32'(pix));
        chk({name, "_hs"}, 32'(hsync_out), 32'(hs));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        pix_ce = 1'b0;
        reset  = 1'b1;
        #1;
        chk("rst_pix_out", 32'(pix_out), 32'h0);
        chk("rst_hsync_out", 32'(hsync_out), 32'h0);
        chk("rst_vsync_out", 32'(vsync_out), 32'h0);
        chk("rst_de_out", 32'(de_out), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Text frames with one vsync pulse each
    task automatic frames(input int n, input logic [7:0] att, input logic pin, input logic cur);
        stim_t s;
        for (int f = 0; f < n; f++) begin
            for (int p = 0; p < 4; p++) begin
                s = idle(); s.att = att; s.pin = pin; s.cur = cur;
                step(s);
            end
            s = idle(); s.att = att; s.pin = pin; s.cur = cur; s.vs = 1'b1;
            step(s);
        end
    endtask

    // Scoreboard monitor: pop on pix_ce edges, require held outputs on stalled edges
    initial begin
        exp_t last = '0;
        logic ce_s, rst_s;
        forever begin
            @(posedge clk);
            ce_s  = pix_ce;
            rst_s = reset;
            #1;
            if (rst_s) begin
                last = '0;
            end else begin
                if (ce_s) begin
                    chk("queue_has_entry", 32'(q.size() > 0), 32'h1);
                    if (q.size() > 0) last = q.pop_front();
                end
                chk("pix_out", 32'(pix_out), 32'(last.pix));
                chk("hsync_out", 32'(hsync_out), 32'(last.hs));
                chk("vsync_out", 32'(vsync_out), 32'(last.vs));
                chk("de_out", 32'(de_out), 32'(last.de));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        stim_t s;
        reset = 1'b1; pix_ce = 1'b0; bus_wr = 1'b0; ff_clr = 1'b0; bus_din = '0; att_byte = '0;
        pix_in = 1'b0; pix_gfx = '0; grph_mode = 1'b0; cursor = 1'b0; display_enable = 1'b0;
        hsync = 1'b0; vsync = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        apply_reset();

        // PAS on, default palette: attribute 1E with dot lit -> entry E
        bus_write(8'h20); bus_clear();
        s = idle(); s.att = 8'h1E; s.pin = 1'b1;
        step(s); step(s);
        check_now("text_1e", 6'h0E, 1'b0);

        // Palette entry 3 <- 2A, then graphics pixel 3
        bus_write(8'h03); bus_write(8'h2A); bus_write(8'h23); bus_clear();
        s = idle(); s.gm = 1'b1; s.gfx = 4'h3;
        step(s); step(s);
        check_now("gfx_pal3", 6'h2A, 1'b0);

        // Dropped write under ff_clr, then OVERSCAN = 15 shown outside display
        bus_write(8'h01);
        s = idle(); s.ce = 1'b0; s.wr = 1'b1; s.clr = 1'b1; s.din = 8'h07; step(s);
        bus_write(8'h31); bus_write(8'h15);
        s = idle(); s.de = 1'b0; s.att = 8'h1E; s.pin = 1'b1;
        step(s); step(s);
        check_now("overscan", 6'h15, 1'b0);

        // hsync blanks and is delayed by two pixels
        s = idle(); s.hs = 1'b1; s.att = 8'h1E; s.pin = 1'b1;
        step(s);
        s.hs = 1'b0; step(s);
        check_now("hsync_blank", 6'h00, 1'b1);

        // Stall pattern 1-0-0-1
        s = idle(); s.att = 8'h2C; s.pin = 1'b1; step(s);
        s.ce = 1'b0; s.att = 8'h05; step(s); step(s);
        s.ce = 1'b1; step(s); step(s);

        // Character blink, then blink disabled, then cursor blink
        frames(36, 8'h8F, 1'b1, 1'b0);
        bus_write(8'h30); bus_write(8'h00);
        frames(20, 8'h8F, 1'b1, 1'b0);
        bus_write(8'h30); bus_write(8'h08);
        frames(36, 8'h87, 1'b0, 1'b1);

        // Reset in the middle of a line
        apply_reset();
        bus_write(8'h20); bus_clear();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            s.ce  = ($urandom_range(0, 9) < 8);
            s.wr  = ($urandom_range(0, 9) == 0);
            s.clr = ($urandom_range(0, 39) == 0);
            s.din = 8'($urandom);
            if ($urandom_range(0, 4) != 0) s.din[5] = 1'b1;
            s.att = 8'($urandom);
            s.pin = 1'($urandom);
            s.gfx = 4'($urandom);
            s.gm  = ($urandom_range(0, 3) == 0);
            s.cur = ($urandom_range(0, 7) == 0);
            s.de  = ($urandom_range(0, 9) != 0);
            s.hs  = ($urandom_range(0, 19) == 0);
            s.vs  = ($urandom_range(0, 14) == 0);
            step(s);
            if (i == 1500) apply_reset();
        end

        s = idle();
        repeat (4) step(s);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
